// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
// Sized for a 32-entry, 32-bit register bank.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int X0   = 0;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-of-N arbiter: round-robin from ptr_i, or fixed priority
// (index 0 highest) when RR is 0. Emits a one-hot grant and its index.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter  int N_SRC = 3,
    parameter  int RR    = 1,
    localparam int IW    = idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] valid_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_SRC-1:0] grant_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin
        int base;
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = |valid_i;
        base    = (RR != 0) ? int'(ptr_i) : 0;
        cand    = 0;
        // Scan from the farthest offset down so the nearest valid source wins.
        for (int off = N_SRC - 1; off >= 0; off--) begin
            cand = base + off;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            if (valid_i[cand]) begin
                idx_o = IW'(cand);
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates writeback sources onto the register bank's single write port and
// keeps a busy scoreboard for issue WAW blocking and read-hazard detection.
module rf_wb_arbiter
    import rf_pkg::idx_w;
    import rf_pkg::X0;
#(
    parameter int N_SRC = 3,
    parameter int DW    = rf_pkg::DW,
    parameter int AW    = rf_pkg::AW,
    parameter int RR    = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_SRC-1:0]    src_valid,
    output logic [N_SRC-1:0]    src_ready,
    input  logic [N_SRC*AW-1:0] src_rd,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic [AW-1:0]       read1,
    input  logic [AW-1:0]       read2,
    output logic                hazard1,
    output logic                hazard2,
    output logic                regwrite,
    output logic [AW-1:0]       wrreg,
    output logic [DW-1:0]       wrdata
);

    localparam int IW     = idx_w(N_SRC);
    localparam int NREG_L = 1 << AW;

    logic [AW-1:0]     rd_a   [N_SRC];
    logic [DW-1:0]     data_a [N_SRC];

    logic [N_SRC-1:0]  arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREG_L-1:0] busy_q, busy_d;
    logic              regwrite_q, regwrite_d;
    logic [AW-1:0]     wrreg_q, wrreg_d;
    logic [DW-1:0]     wrdata_q, wrdata_d;

    logic              hs;
    logic [AW-1:0]     sel_rd;
    logic [DW-1:0]     sel_data;
    logic              issue_fire;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign rd_a[gi]   = src_rd[gi*AW +: AW];
            assign data_a[gi] = src_data[gi*DW +: DW];
        end
    endgenerate

    rr_arbiter #(
        .N_SRC (N_SRC),
        .RR    (RR)
    ) u_arb (
        .valid_i (src_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // The grant only ever covers valid sources, so any valid means a handshake.
    assign src_ready = arb_grant;
    assign hs        = arb_any;
    assign sel_rd    = rd_a[arb_idx];
    assign sel_data  = data_a[arb_idx];

    assign issue_ready = !busy_q[issue_rd] || (issue_rd == AW'(X0));
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != AW'(X0));

    assign hazard1 = busy_q[read1] && (read1 != AW'(X0));
    assign hazard2 = busy_q[read2] && (read2 != AW'(X0));

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;
        regwrite_d = 1'b0;
        wrreg_d    = wrreg_q;
        wrdata_d   = wrdata_q;
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (hs) begin
            // Issue is blocked while busy, so this clear never collides with the set above.
            busy_d[sel_rd] = 1'b0;
            regwrite_d     = (sel_rd != AW'(X0));
            wrreg_d        = sel_rd;
            wrdata_d       = sel_data;
            if (RR != 0) begin
                rr_ptr_d = (arb_idx == IW'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            wrreg_q    <= '0;
            wrdata_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            wrreg_q    <= wrreg_d;
            wrdata_q   <= wrdata_d;
        end
    end

    assign regwrite = regwrite_q;
    assign wrreg    = wrreg_q;
    assign wrdata   = wrdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: fixed vector table, directed scoreboard/reset
// sequences, then randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src_valid;
    logic [N*AW-1:0] src_rd;
    logic [N*DW-1:0] src_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd, read1, read2;

    logic [N-1:0]    src_ready, src_ready_f;
    logic            issue_ready, issue_ready_f;
    logic            hazard1, hazard2, hazard1_f, hazard2_f;
    logic            regwrite, regwrite_f;
    logic [AW-1:0]   wrreg, wrreg_f;
    logic [DW-1:0]   wrdata, wrdata_f;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.N_SRC(N), .DW(DW), .AW(AW), .RR(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rd(src_rd), .src_data(src_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .read1(read1), .read2(read2), .hazard1(hazard1), .hazard2(hazard2),
        .regwrite(regwrite), .wrreg(wrreg), .wrdata(wrdata)
    );

    rf_wb_arbiter #(.N_SRC(N), .DW(DW), .AW(AW), .RR(0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .src_valid(src_valid), .src_ready(src_ready_f),
        .src_rd(src_rd), .src_data(src_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_f),
        .read1(read1), .read2(read2), .hazard1(hazard1_f), .hazard2(hazard2_f),
        .regwrite(regwrite_f), .wrreg(wrreg_f), .wrdata(wrdata_f)
    );

    typedef struct packed {
        logic [N-1:0]  valid;
        logic [N-1:0]  rdy_rr;
        logic [N-1:0]  rdy_fp;
        logic          rw;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        src_rd[i*AW +: AW] = rd;
        src_data[i*DW +: DW] = d;
    endtask

    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h2222_0001;
    localparam logic [DW-1:0] D2 = 32'h3333_0002;

    // Behavioural reference state for the random phase.
    bit            busy_m [32];
    int            ptr_m;
    logic [AW-1:0] rds_m  [N];
    logic [DW-1:0] dat_m  [N];
    logic          rw_m;
    logic [AW-1:0] wr_m;
    logic [DW-1:0] wd_m;

    initial begin
        // Grant history from reset with sources 0/1/2 writing rd 1/2/3.
        vec[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 5'd0, 32'd0};
        vec[1]  = '{3'b010, 3'b010, 3'b010, 1'b1, 5'd2, D1};
        vec[2]  = '{3'b111, 3'b100, 3'b001, 1'b1, 5'd3, D2};
        vec[3]  = '{3'b111, 3'b001, 3'b001, 1'b1, 5'd1, D0};
        vec[4]  = '{3'b111, 3'b010, 3'b001, 1'b1, 5'd2, D1};
        vec[5]  = '{3'b111, 3'b100, 3'b001, 1'b1, 5'd3, D2};
        vec[6]  = '{3'b101, 3'b001, 3'b001, 1'b1, 5'd1, D0};
        vec[7]  = '{3'b101, 3'b100, 3'b001, 1'b1, 5'd3, D2};
        vec[8]  = '{3'b100, 3'b100, 3'b100, 1'b1, 5'd3, D2};
        vec[9]  = '{3'b000, 3'b000, 3'b000, 1'b0, 5'd3, D2};
        vec[10] = '{3'b011, 3'b001, 3'b001, 1'b1, 5'd1, D0};
        vec[11] = '{3'b011, 3'b010, 3'b001, 1'b1, 5'd2, D1};
        vec[12] = '{3'b011, 3'b001, 3'b001, 1'b1, 5'd1, D0};

        // Reset with every source requesting: nothing may be written.
        rst = 1'b1;
        src_valid = '1;
        src_rd = '0;
        src_data = '0;
        set_src(0, 5'd1, D0);
        set_src(1, 5'd2, D1);
        set_src(2, 5'd3, D2);
        issue_valid = 1'b0;
        issue_rd = 5'd3;
        read1 = 5'd3;
        read2 = 5'd1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_regwrite", regwrite, 0);
            chk("rst_wrreg", wrreg, 0);
            chk("rst_wrdata", wrdata, 0);
            chk("rst_hazard1", hazard1, 0);
            chk("rst_hazard2", hazard2, 0);
            chk("rst_issue_ready", issue_ready, 1);
            $display("reset cycle %0d regwrite=%b wrreg=%0d", c, regwrite, wrreg);
        end
        src_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            src_valid = vec[i].valid;
            #1;
            chk("tbl_ready_rr", src_ready, vec[i].rdy_rr);
            chk("tbl_ready_fp", src_ready_f, vec[i].rdy_fp);
            tick();
            chk("tbl_regwrite", regwrite, vec[i].rw);
            chk("tbl_wrreg", wrreg, vec[i].wr);
            chk("tbl_wrdata", wrdata, vec[i].wd);
            $display("row %0d valid=%b ready=%b ready_fp=%b -> regwrite=%b wrreg=%0d wrdata=%h",
                     i, vec[i].valid, vec[i].rdy_rr, vec[i].rdy_fp, regwrite, wrreg, wrdata);
        end
        src_valid = '0;

        // Scoreboard: issue rd 7, see the hazard, then retire it.
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        #1;
        chk("sb_issue_ready_free", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        read1 = 5'd7;
        read2 = 5'd8;
        #1;
        chk("sb_hazard1_busy", hazard1, 1);
        chk("sb_hazard2_free", hazard2, 0);
        chk("sb_issue_ready_waw", issue_ready, 0);
        set_src(1, 5'd7, 32'hCAFE_0007);
        src_valid = 3'b010;
        #1;
        chk("sb_ready", src_ready, 3'b010);
        tick();
        src_valid = '0;
        chk("sb_regwrite", regwrite, 1);
        chk("sb_wrreg", wrreg, 7);
        chk("sb_wrdata", wrdata, 32'hCAFE_0007);
        chk("sb_hazard1_clear", hazard1, 0);
        chk("sb_issue_ready_again", issue_ready, 1);
        $display("scoreboard rd7 retired regwrite=%b wrreg=%0d", regwrite, wrreg);

        issue_valid = 1'b1;
        issue_rd = 5'd0;
        #1;
        chk("sb_x0_issue_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        read1 = 5'd0;
        #1;
        chk("sb_x0_hazard", hazard1, 0);

        // Set rd 10 and clear rd 9 on the same edge.
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        tick();
        issue_rd = 5'd10;
        set_src(0, 5'd9, 32'h0000_0909);
        src_valid = 3'b001;
        #1;
        chk("sc_ready", src_ready, 3'b001);
        tick();
        issue_valid = 1'b0;
        src_valid = '0;
        read1 = 5'd9;
        read2 = 5'd10;
        #1;
        chk("sc_hazard_cleared", hazard1, 0);
        chk("sc_hazard_set", hazard2, 1);
        chk("sc_wrreg", wrreg, 9);
        set_src(2, 5'd10, 32'h0000_1010);
        src_valid = 3'b100;
        tick();
        src_valid = '0;
        chk("sc_hazard2_retired", hazard2, 0);
        $display("same-edge set/clear wrreg=%0d", wrreg);

        // Write to x0 completes the handshake without a bank write.
        set_src(0, 5'd0, 32'h5555_AAAA);
        src_valid = 3'b001;
        #1;
        chk("x0_ready", src_ready, 3'b001);
        tick();
        src_valid = '0;
        chk("x0_regwrite", regwrite, 0);
        chk("x0_wrreg", wrreg, 0);
        chk("x0_wrdata", wrdata, 32'h5555_AAAA);
        $display("x0 write regwrite=%b wrdata=%h", regwrite, wrdata);

        // Reset in the cycle after a grant.
        issue_valid = 1'b1;
        issue_rd = 5'd13;
        tick();
        issue_rd = 5'd14;
        set_src(2, 5'd13, 32'h1313_1313);
        src_valid = 3'b100;
        tick();
        issue_valid = 1'b0;
        chk("mr_regwrite_before", regwrite, 1);
        rst = 1'b1;
        src_valid = '1;
        read1 = 5'd13;
        read2 = 5'd14;
        #1;
        chk("mr_busy14_before", hazard2, 1);
        tick();
        chk("mr_regwrite", regwrite, 0);
        chk("mr_wrreg", wrreg, 0);
        chk("mr_wrdata", wrdata, 0);
        chk("mr_busy_cleared", hazard2, 0);
        rst = 1'b0;
        #1;
        chk("mr_ptr_reset", src_ready, 3'b001);
        src_valid = '0;
        tick();
        $display("mid-op reset regwrite=%b wrreg=%0d", regwrite, wrreg);

        // Randomized traffic against the behavioural model.
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        ptr_m = 0;
        rw_m = 1'b0;
        wr_m = '0;
        wd_m = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            int f;
            logic exp_ir;
            logic [N-1:0] exp_rdy;
            logic [N-1:0] exp_fp;
            src_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                rds_m[i] = AW'($urandom_range(0, 7));
                dat_m[i] = $urandom;
                set_src(i, rds_m[i], dat_m[i]);
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = AW'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (rds_m[i] == issue_rd) issue_valid = 1'b0;
            end
            read1 = AW'($urandom_range(0, 7));
            read2 = AW'($urandom_range(0, 7));
            #1;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && src_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
            f = -1;
            for (int k = N - 1; k >= 0; k--) begin
                if (src_valid[k]) f = k;
            end
            exp_rdy = (g < 0) ? '0 : N'(1 << g);
            exp_fp  = (f < 0) ? '0 : N'(1 << f);
            exp_ir  = !busy_m[issue_rd] || (issue_rd == 0);
            chk("rnd_ready", src_ready, exp_rdy);
            chk("rnd_ready_fp", src_ready_f, exp_fp);
            chk("rnd_issue_ready", issue_ready, exp_ir);
            chk("rnd_hazard1", hazard1, busy_m[read1] && read1 != 0);
            chk("rnd_hazard2", hazard2, busy_m[read2] && read2 != 0);
            if (issue_valid && exp_ir && issue_rd != 0) busy_m[issue_rd] = 1'b1;
            if (g >= 0) begin
                busy_m[rds_m[g]] = 1'b0;
                rw_m  = (rds_m[g] != 0);
                wr_m  = rds_m[g];
                wd_m  = dat_m[g];
                ptr_m = (g + 1) % N;
            end else begin
                rw_m = 1'b0;
            end
            tick();
            chk("rnd_regwrite", regwrite, rw_m);
            chk("rnd_wrreg", wrreg, wr_m);
            chk("rnd_wrdata", wrdata, wd_m);
            $display("rnd %0d valid=%b grant=%0d regwrite=%b wrreg=%0d", cyc, src_valid, g, regwrite, wrreg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
